// File: rtl/rollo_iii_encrypt.sv
// Hardware-scaled ROLLO-III encryption: LFSR-generated h, e1, e2, then c = e1 + e2*h
// over GF(2^M)[x]/(x^N - 1); the ciphertext is streamed one coefficient per cycle.
module rollo_iii_encrypt #(
  parameter int unsigned M          = 8,
  parameter logic [M:0]  FIELD_POLY = 9'h11B,
  parameter int unsigned N          = 17,
  parameter logic [31:0] SEED       = 32'hACE1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  output logic [31:0] data,
  output logic        ready
);

  localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW       = IW + 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [1:0]      seg_q, seg_d;
  logic [IW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [31:0]     data_q, data_d;
  logic [M-1:0]    h_q  [N];
  logic [M-1:0]    h_d  [N];
  logic [M-1:0]    e2_q [N];
  logic [M-1:0]    e2_d [N];
  logic [M-1:0]    c_q  [N];
  logic [M-1:0]    c_d  [N];

  logic [M-1:0]    coef;
  logic [M-1:0]    prod;
  logic [SW-1:0]   sum;
  logic [IW-1:0]   sidx;

  // Galois LFSR, one shift per call.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Shift-and-add field multiply, reducing after every doubling of the multiplicand.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0]   aa;
    logic [M-1:0] p;
    aa = {1'b0, a};
    p  = '0;
    for (int unsigned t = 0; t < M; t++) begin
      if (b[t]) p = p ^ aa[M-1:0];
      aa = aa << 1;
      if (aa[M]) aa = aa ^ FIELD_POLY;
    end
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_GEN;
      S_GEN:  if (seg_q == 2'd2 && k_q == IW'(N - 1)) state_d = S_MUL;
      S_MUL:  if (i_q == IW'(N - 1) && j_q == IW'(N - 1)) state_d = S_DONE;
      S_DONE: if (start) state_d = S_GEN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    lfsr_d  = lfsr_q;
    seg_d   = seg_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    data_d  = '0;
    h_d     = h_q;
    e2_d    = e2_q;
    c_d     = c_q;
    coef    = '0;
    prod    = '0;
    sum     = '0;
    sidx    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d = SEED_EFF;
          seg_d  = '0;
          k_d    = '0;
          i_d    = '0;
          j_d    = '0;
          idx_d  = '0;
        end
      end

      // seg 0 fills h, seg 1 fills e1 directly into c, seg 2 fills e2.
      S_GEN: begin
        lfsr_d = lfsr_step(lfsr_q);
        coef   = lfsr_d[M-1:0];
        case (seg_q)
          2'd0:    h_d[k_q]  = coef;
          2'd1:    c_d[k_q]  = coef;
          default: e2_d[k_q] = coef;
        endcase
        if (k_q == IW'(N - 1)) begin
          k_d   = '0;
          seg_d = seg_q + 2'd1;
        end else begin
          k_d = k_q + IW'(1);
        end
      end

      S_MUL: begin
        prod = gf_mul(e2_q[i_q], h_q[j_q]);
        sum  = SW'(i_q) + SW'(j_q);
        if (sum >= SW'(N)) sum = sum - SW'(N);
        sidx = sum[IW-1:0];
        c_d[sidx] = c_q[sidx] ^ prod;
        if (j_q == IW'(N - 1)) begin
          j_d = '0;
          i_d = (i_q == IW'(N - 1)) ? '0 : i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        idx_d = '0;
      end

      S_DONE: begin
        if (start) begin
          lfsr_d = SEED_EFF;
          seg_d  = '0;
          k_d    = '0;
          i_d    = '0;
          j_d    = '0;
          idx_d  = '0;
        end else begin
          ready_d = 1'b1;
          data_d  = {16'(idx_q), 16'(c_q[idx_q])};
          idx_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        end
      end

      default: ;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      lfsr_q  <= SEED_EFF;
      seg_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      seg_q   <= seg_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  // Coefficient storage is fully rewritten by GEN, so it carries no reset.
  always_ff @(posedge clk) begin
    h_q  <= h_d;
    e2_q <= e2_d;
    c_q  <= c_d;
  end

  assign data  = data_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_rollo_iii_encrypt.sv
// Bench for rollo_iii_encrypt: expected readout words are queued at start time and
// checked by an independent monitor whenever ready is high; latency checked per run.
module tb_rollo_iii_encrypt;

  localparam int N       = 17;
  localparam int LAT     = 341;
  localparam int NW      = 20;
  localparam int TIMEOUT = 1000;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [31:0] data;
  logic        ready;

  int n_chk;
  int n_fail;

  logic [31:0] exp_q [$];
  logic [7:0]  hm  [N];
  logic [7:0]  e2m [N];
  logic [7:0]  cm  [N];

  rollo_iii_encrypt dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .data  (data),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference field multiply (Horner, MSB first) over GF(2^8)/0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] p);
    return p[7] ? ((p << 1) ^ 8'h1B) : (p << 1);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int t = 7; t >= 0; t--) begin
      p = xtime(p);
      if (b[t]) p = p ^ a;
    end
    return p;
  endfunction

  task automatic build_model();
    logic [31:0] s;
    logic [7:0]  v;
    s = 32'hACE1;
    for (int t = 0; t < 3 * N; t++) begin
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      v = s[7:0];
      if (t < N)          hm[t]       = v;
      else if (t < 2 * N) cm[t - N]   = v;
      else                e2m[t - 2*N] = v;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        cm[(i + j) % N] = cm[(i + j) % N] ^ ref_mul(e2m[i], hm[j]);
  endtask

  task automatic push_words(input int n);
    for (int w = 0; w < n; w++)
      exp_q.push_back({16'(w % N), 16'(cm[w % N])});
  endtask

  // Caller sits 1 time unit after a rising edge; start is sampled on the next edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until ready; optionally releases a held start.
  task automatic wait_ready(input string name, input int drop_at);
    int cyc;
    cyc = 0;
    while (ready !== 1'b1 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == drop_at) start = 1'b0;
    end
    $display("%s runtime = %0d cycles", name, cyc);
    n_chk++;
    if (cyc != LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, LAT);
    end
  endtask

  task automatic read_words();
    repeat (NW - 1) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  // Monitor: pop one expected word per ready cycle; otherwise outputs must be idle.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL readout: unexpected word %h, expected none", data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_fail++;
          $display("FAIL readout: got %h, expected %h", data, e);
        end
      end
    end else begin
      n_chk++;
      if (ready !== 1'b0 || data !== 32'h0) begin
        n_fail++;
        $display("FAIL idle outputs: got ready=%b data=%h, expected ready=0 data=0", ready, data);
      end
    end
  end

  initial begin
    logic seen;
    n_chk  = 0;
    n_fail = 0;
    rst_b  = 1'b0;
    start  = 1'b0;
    build_model();

    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    check_bit("reset ready", ready, 1'b0);
    n_chk++;
    if (data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset data: got %h, expected 00000000", data);
    end
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Plain run, then restart from DONE: same latency and ciphertext.
    push_words(NW);
    pulse_start();
    check_bit("ready low after start", ready, 1'b0);
    wait_ready("first", 0);
    read_words();
    push_words(NW);
    pulse_start();
    check_bit("ready drops on restart", ready, 1'b0);
    wait_ready("restart", 0);
    read_words();

    // Back to IDLE, then start held high through GEN and most of MUL.
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    push_words(NW);
    start = 1'b1;
    @(posedge clk); #1;
    wait_ready("held start", 300);
    read_words();

    // Reset in the middle of MUL, confirm it stays idle, then rerun.
    pulse_start();
    repeat (100) @(posedge clk);
    #1;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("ready after mid-MUL reset", ready, 1'b0);
    rst_b = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (ready === 1'b1) seen = 1'b1;
    end
    check_bit("no completion after abort", seen, 1'b0);
    push_words(NW);
    pulse_start();
    wait_ready("after reset", 0);
    read_words();

    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d words left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
